// File: rtl/regfile_bank.sv
// regfile_bank: storage half of the 32 x 64-bit LEGv8 register file.
// Holds the architectural registers, exposes them as one flattened bus and
// keeps a 2-bit per-register in-flight write scoreboard for the hazard unit.
// XZR (ZERO_REG) has no storage and no scoreboard entry.
// Optional feature macro: REGFILE_BYPASS_EN (write-first bypass of the
// retiring write onto regs_out and pending in the same cycle).
module regfile_bank #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic [4:0]                wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      claim_en,
  input  logic [4:0]                claim_addr,
  output logic [NUM_REGS*WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]       pending,
  output logic                      sb_overflow
);

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 2;

  logic [NUM_REGS-1:0] w_wr_hit;
  logic [NUM_REGS-1:0] w_claim_hit;
  logic [NUM_REGS-1:0] w_ovf_req;
  logic                r_ovf;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (g == ZERO_REG) begin : g_zero
      // XZR reads as zero and is invisible to the scoreboard
      assign w_wr_hit[g]                = 1'b0;
      assign w_claim_hit[g]             = 1'b0;
      assign w_ovf_req[g]               = 1'b0;
      assign regs_out[g*WIDTH +: WIDTH] = '0;
      assign pending[g]                 = 1'b0;
    end else begin : g_arch
      logic [WIDTH-1:0] r_q;
      logic [CW-1:0]    r_cnt;

      assign w_wr_hit[g]    = wr_en    && (wr_addr    == AW'(g));
      assign w_claim_hit[g] = claim_en && (claim_addr == AW'(g));
      // A claim on a saturated counter with no offsetting write is an overflow
      assign w_ovf_req[g]   = w_claim_hit[g] && !w_wr_hit[g] && (r_cnt == CW'(3));

      // Architectural register storage, written by WB
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_q <= '0;
        end else if (w_wr_hit[g]) begin
          r_q <= wr_data;
        end
      end

      // In-flight write count: +1 per claim, -1 per retire, saturating both ways
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt <= '0;
        end else if (w_claim_hit[g] && !w_wr_hit[g]) begin
          if (r_cnt != CW'(3)) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end else if (w_wr_hit[g] && !w_claim_hit[g]) begin
          if (r_cnt != CW'(0)) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
      end

`ifdef REGFILE_BYPASS_EN
      // Write-first view: the retiring value and post-decrement count show now
      assign regs_out[g*WIDTH +: WIDTH] = w_wr_hit[g] ? wr_data : r_q;
      assign pending[g] = w_wr_hit[g] ? (r_cnt > CW'(1)) : (r_cnt != CW'(0));
`else
      // Registered view only
      assign regs_out[g*WIDTH +: WIDTH] = r_q;
      assign pending[g]                 = (r_cnt != CW'(0));
`endif
    end
  end

  // Sticky scoreboard overflow flag, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (|w_ovf_req) begin
      r_ovf <= 1'b1;
    end
  end

  assign sb_overflow = r_ovf;

endmodule
